fnd_scan_controller: RTL

//  Upstream driver for the 4-digit BCD-to-FND decoder. Captures a binary value and

---
 rtl/fnd_scan_controller.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: captures a binary value, converts it to four BCD digits with a
// sequential double-dabble engine and time-multiplexes the digits onto one BCD bus
// (o_bcd, o_digitSelect, o_blank) for a 4-digit BCD-to-FND decoder.
// Optional build macro: FND_LZ_BLANK_EN enables leading-zero suppression.
module fnd_scan_controller #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 1_000,
  parameter int unsigned VALUE_W = 14
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [VALUE_W-1:0] i_value,
  input  logic               i_load,
  input  logic               i_en,
  output logic               o_busy,
  output logic               o_ovf,
  output logic [3:0]         o_bcd,
  output logic [1:0]         o_digitSelect,
  output logic               o_blank
);

  localparam int unsigned DIV    = CLK_HZ / SCAN_HZ;
  localparam int unsigned TICK_W = $clog2(DIV);
  localparam int unsigned ITER_W = $clog2(VALUE_W + 1);
  localparam int unsigned CMP_W  = (VALUE_W > 14) ? VALUE_W : 14;
  localparam int unsigned BCD_W  = 16;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(VALUE_W - 1);
  localparam logic [CMP_W-1:0]  MAX_DISP  = CMP_W'(9999);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Conversion engine state
  state_t              state_q, state_d;
  logic [VALUE_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [BCD_W-1:0]    disp_q, disp_d;
  logic                busy_d;
  logic                ovf_d;
  logic [BCD_W-1:0]    adj;
  logic                value_over;

  // Scan engine state
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic                scan_wrap;
  logic [1:0]          sel_d;
  logic [3:0]          bcd_out_d;
  logic                blank_d;
`ifdef FND_LZ_BLANK_EN
  logic                lz_q, lz_d;
`endif

  // Values above the 4-digit range are clamped to 9999 and flagged
  assign value_over = (CMP_W'(i_value) > MAX_DISP);

  // Conversion FSM state register and datapath registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      disp_q  <= '0;
      o_busy  <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      disp_q  <= disp_d;
      o_busy  <= busy_d;
      o_ovf   <= ovf_d;
    end
  end

  // Conversion FSM next-state and datapath logic
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    disp_d  = disp_q;
    busy_d  = o_busy;
    ovf_d   = o_ovf;
    adj     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_load) begin
          state_d = ST_SHIFT;
          bin_d   = value_over ? VALUE_W'(9999) : i_value;
          bcd_d   = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
          ovf_d   = value_over;
        end
      end
      ST_SHIFT: begin
        // One double-dabble step: correct nibbles >= 5, then shift left by one
        adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
          if (adj[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
          end
        end
        {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == ITER_LAST) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
        end
      end
      ST_DONE: begin
        // All four digits move to the display in one edge so no frame is torn
        disp_d  = bcd_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scan registers: refresh tick, digit select, digit bus and blank flag
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tick_q        <= '0;
      o_digitSelect <= '0;
      o_bcd         <= '0;
      o_blank       <= 1'b1;
`ifdef FND_LZ_BLANK_EN
      lz_q          <= 1'b0;
`endif
    end else begin
      tick_q        <= tick_d;
      o_digitSelect <= sel_d;
      o_bcd         <= bcd_out_d;
      o_blank       <= blank_d;
`ifdef FND_LZ_BLANK_EN
      lz_q          <= lz_d;
`endif
    end
  end

  // Scan next-state: advance the digit on each tick wrap, sampling the display regs
  always_comb begin
    scan_wrap = (tick_q == TICK_LAST);
    tick_d    = scan_wrap ? '0 : tick_q + TICK_W'(1);
    sel_d     = o_digitSelect;
    bcd_out_d = o_bcd;
    if (scan_wrap) begin
      sel_d     = o_digitSelect + 2'd1;
      bcd_out_d = disp_q[{sel_d, 2'b00} +: 4];
    end
`ifdef FND_LZ_BLANK_EN
    // Leading-zero flag tracks the digit on the bus, so it changes with o_bcd
    lz_d = lz_q;
    if (scan_wrap) begin
      unique case (sel_d)
        2'd0:    lz_d = 1'b0;
        2'd1:    lz_d = (disp_q[15:4] == 12'd0);
        2'd2:    lz_d = (disp_q[15:8] == 8'd0);
        2'd3:    lz_d = (disp_q[15:12] == 4'd0);
        default: lz_d = 1'b0;
      endcase
    end
    blank_d = ~i_en | lz_d;
`else
    blank_d = ~i_en;
`endif
  end

endmodule
